// File: rtl/fsm_scan_ctrl.sv
// Scans a captured word MSB first through a 000/111 run detector, counting hits and recording the first hit position.
// Latency: busy for WIDTH cycles, done pulses WIDTH edges after start is accepted; start is ignored unless IDLE.
module fsm_scan_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4,
    parameter int POS_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    input  logic [1:0]       mode,
    output logic             busy,
    output logic             done,
    output logic             bit_out,
    output logic             hit,
    output logic [CNT_W-1:0] count,
    output logic             found,
    output logic [POS_W-1:0] first_pos
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [POS_W-1:0] LAST_K = POS_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [1:0]         mode_q, mode_d;
    logic [1:0]         hist_q, hist_d;
    logic [POS_W-1:0]   k_q, k_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               bit_out_q, bit_out_d;
    logic               hit_q, hit_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               found_q, found_d;
    logic [POS_W-1:0]   first_pos_q, first_pos_d;
    logic               cur_bit;
    logic               match;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        mode_d      = mode_q;
        hist_d      = hist_q;
        k_d         = k_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        bit_out_d   = bit_out_q;
        hit_d       = 1'b0;
        count_d     = count_q;
        found_d     = found_q;
        first_pos_d = first_pos_q;
        cur_bit     = shreg_q[WIDTH-1];
        match       = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    shreg_d     = data;
                    mode_d      = mode;
                    hist_d      = 2'b00;
                    k_d         = '0;
                    count_d     = '0;
                    found_d     = 1'b0;
                    first_pos_d = '0;
                    busy_d      = 1'b1;
                    state_d     = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // History only qualifies once two bits of this word have been consumed.
                match = (k_q > POS_W'(1)) &&
                        ((mode_q[0] && hist_q == 2'b00 && !cur_bit) ||
                         (mode_q[1] && hist_q == 2'b11 &&  cur_bit));
                bit_out_d = cur_bit;
                shreg_d   = shreg_q << 1;
                hit_d     = match;
                hist_d    = {hist_q[0], cur_bit};
                k_d       = k_q + POS_W'(1);
                if (match) begin
                    if (count_q != {CNT_W{1'b1}}) begin
                        count_d = count_q + CNT_W'(1);
                    end
                    if (!found_q) begin
                        found_d     = 1'b1;
                        first_pos_d = k_q;
                    end
                end
                if (k_q == LAST_K) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            shreg_q     <= '0;
            mode_q      <= 2'b00;
            hist_q      <= 2'b00;
            k_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bit_out_q   <= 1'b0;
            hit_q       <= 1'b0;
            count_q     <= '0;
            found_q     <= 1'b0;
            first_pos_q <= '0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            mode_q      <= mode_d;
            hist_q      <= hist_d;
            k_q         <= k_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            bit_out_q   <= bit_out_d;
            hit_q       <= hit_d;
            count_q     <= count_d;
            found_q     <= found_d;
            first_pos_q <= first_pos_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign bit_out   = bit_out_q;
    assign hit       = hit_q;
    assign count     = count_q;
    assign found     = found_q;
    assign first_pos = first_pos_q;

endmodule

// File: tb/tb_fsm_scan_ctrl.sv
// Directed bench for fsm_scan_ctrl: expected scan results are queued at acceptance and checked per bit and at done.
module tb_fsm_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] data = 8'h00;
    logic [1:0] mode = 2'b00;
    logic       busy, done, bit_out, hit, found;
    logic [3:0] count;
    logic [2:0] first_pos;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] dat;
        logic [7:0] hit_mask;   // bit k set when the k-th consumed bit completes a hit
        logic [3:0] cnt;
        logic       fnd;
        logic [2:0] pos;
    } exp_t;

    exp_t sb[$];

    fsm_scan_ctrl #(.WIDTH(8), .CNT_W(4), .POS_W(3)) dut (
        .clk(clk), .reset(reset), .start(start), .data(data), .mode(mode),
        .busy(busy), .done(done), .bit_out(bit_out), .hit(hit),
        .count(count), .found(found), .first_pos(first_pos)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Requests a scan and returns how many edges passed before busy rose.
    task automatic accept(input logic [7:0] d, input logic [1:0] m, input exp_t e, output int edges);
        data  = d;
        mode  = m;
        start = 1'b1;
        edges = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            edges++;
            if (busy === 1'b1) break;
        end
        chk("accept_busy", busy, 1);
        chk("accept_hit", hit, 0);
        sb.push_back(e);
    endtask

    // Consumes n bits of the front scoreboard entry; pops and checks results when the scan ends.
    task automatic run_bits(input int n, input bit hold_start, input logic [7:0] churn);
        exp_t e;
        e = sb[0];
        if (!hold_start) start = 1'b0;
        for (int k = 0; k < n; k++) begin
            data = churn ^ 8'(k);
            mode = 2'(k);
            tick();
            chk($sformatf("bit_out_k%0d", k), bit_out, e.dat[7-k]);
            chk($sformatf("hit_k%0d", k), hit, e.hit_mask[k]);
            if (k < 7) begin
                chk($sformatf("busy_k%0d", k), busy, 1);
                chk($sformatf("done_k%0d", k), done, 0);
            end else begin
                e = sb.pop_front();
                chk("done_pulse", done, 1);
                chk("busy_end", busy, 0);
                chk("count", count, e.cnt);
                chk("found", found, e.fnd);
                if (e.fnd) chk("first_pos", first_pos, e.pos);
            end
        end
    endtask

    task automatic post_idle(input exp_t e);
        tick();
        chk("idle_done", done, 0);
        chk("idle_hit", hit, 0);
        chk("idle_busy", busy, 0);
        chk("idle_count_hold", count, e.cnt);
        chk("idle_found_hold", found, e.fnd);
        chk("idle_bit_out_hold", bit_out, e.dat[0]);
    endtask

    task automatic scan(input logic [7:0] d, input logic [1:0] m, input logic [7:0] mask,
                        input logic [3:0] c, input logic f, input logic [2:0] p);
        exp_t e;
        int   edges;
        e = '{dat: d, hit_mask: mask, cnt: c, fnd: f, pos: p};
        accept(d, m, e, edges);
        run_bits(8, 1'b0, 8'h5A);
        post_idle(e);
    endtask

    initial begin
        exp_t e;
        int   edges;

        reset = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_bit_out", bit_out, 0);
        chk("rst_hit", hit, 0);
        chk("rst_count", count, 0);
        chk("rst_found", found, 0);
        chk("rst_first_pos", first_pos, 0);
        reset = 1'b1;
        tick();
        chk("idle_no_start_busy", busy, 0);

        scan(8'b00011100, 2'b11, 8'b0010_0100, 4'd2, 1'b1, 3'd2);
        scan(8'b00011100, 2'b01, 8'b0000_0100, 4'd1, 1'b1, 3'd2);
        scan(8'b00011100, 2'b10, 8'b0010_0000, 4'd1, 1'b1, 3'd5);
        scan(8'h00,       2'b01, 8'b1111_1100, 4'd6, 1'b1, 3'd2);
        scan(8'b01010101, 2'b11, 8'h00,        4'd0, 1'b0, 3'd0);
        scan(8'hFF,       2'b00, 8'h00,        4'd0, 1'b0, 3'd0);

        // Back-to-back: start held high through the scan and DONE; data churns during the scan.
        e = '{dat: 8'hFF, hit_mask: 8'b1111_1100, cnt: 4'd6, fnd: 1'b1, pos: 3'd2};
        accept(8'hFF, 2'b11, e, edges);
        run_bits(8, 1'b1, 8'h00);
        data = 8'h00;
        mode = 2'b11;
        e = '{dat: 8'h00, hit_mask: 8'b1111_1100, cnt: 4'd6, fnd: 1'b1, pos: 3'd2};
        accept(8'h00, 2'b11, e, edges);
        chk("reaccept_edges", edges, 2);
        start = 1'b0;
        data  = 8'hFF;
        run_bits(8, 1'b0, 8'hFF);
        post_idle(e);

        // Reset after the fourth bit discards the scan in flight.
        e = '{dat: 8'b00011100, hit_mask: 8'b0010_0100, cnt: 4'd2, fnd: 1'b1, pos: 3'd2};
        accept(8'b00011100, 2'b11, e, edges);
        run_bits(4, 1'b0, 8'h00);
        chk("mid_count", count, 1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        void'(sb.pop_front());
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_bit_out", bit_out, 0);
        chk("mrst_hit", hit, 0);
        chk("mrst_count", count, 0);
        chk("mrst_found", found, 0);
        chk("mrst_first_pos", first_pos, 0);
        tick();
        chk("mrst_stays_idle", busy, 0);

        scan(8'b11100011, 2'b11, 8'b0010_0100, 4'd2, 1'b1, 3'd2);

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
